memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Shares the single-port word-addressed program/data memory between the processor and a second requester (DMA/loader port used for program upload and peripheral buffers).
- Grants at most one transaction per cycle to memory.
- Routes the 1-cycle-latency read data back to the owner.
- Fixed CPU priority, with a starvation limiter that guarantees DMA progress.
- Sits between processor/DMA and program_memory inside SOC.

Parameters:
- MAX_STREAK, 4: consecutive contended cycles the CPU may win before DMA is forced a grant (legal 1..255).
- ADDR_W, 32: byte address width on all address ports.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU transaction request
- cpu_address  in  ADDR_W  CPU byte address
- cpu_read  in  1  CPU read (1) / write-or-nop (0)
- cpu_writeData  in  32  CPU store data, pre-lane-aligned
- cpu_writeMask  in  4  CPU byte-lane write enables
- cpu_grant  out  1  CPU transaction accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_readData  out  32  CPU read data
- dma_req, dma_address, dma_read, dma_writeData, dma_writeMask  in  1/ADDR_W/1/32/4  DMA request, same meaning as the CPU ports
- dma_grant  out  1  DMA accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_readData  out  32  DMA read data
- mem_address  out  ADDR_W  to memory
- mem_read  out  1  to memory
- mem_writeData  out  32  to memory
- mem_writeMask  out  4  to memory
- mem_readData  in  32  from memory, valid the cycle after mem_read

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE, streak=0, rd_owner=NONE.
  - cpu_rvalid=dma_rvalid=0; cpu_readData=dma_readData=0.
  - Any in-flight read is dropped: no rvalid after reset release.
- Grant decision (combinational, same cycle as request):
  - Only one requester active: it is granted.
  - Both active: CPU is granted unless streak==MAX_STREAK, in which case DMA is granted.
  - Neither active: no grant.
  - Grants are one-hot or zero.
- A transaction is accepted in a cycle where req and grant are both high.
  - Requester holds address/data stable until granted.
  - Requester may drop req without being granted; nothing is issued.
- Memory side:
  - mem_* mirror the granted requester's fields.
  - With no grant: mem_read=0, mem_writeMask=0, mem_address=0, mem_writeData=0.
  - req with read=0 and writeMask=0 is granted and has no memory effect.
  - req with read=1 forces mem_writeMask=0 (read and write never combine).
- Read return:
  - A granted read registers rd_owner.
  - Next cycle, the owner's rvalid=1 for exactly one cycle and its readData=mem_readData.
  - readData holds its value until the next rvalid for that requester.
  - Back-to-back reads from alternating requesters each get their own rvalid on consecutive cycles.
- Streak counter (width clog2(MAX_STREAK+1)):
  - Increments, saturating at MAX_STREAK, when the CPU is granted while dma_req=1.
  - Clears when DMA is granted or dma_req=0.
- State machine, tracking last owner:
  - States: IDLE, CPU_OWN, DMA_OWN.
  - Moves to CPU_OWN / DMA_OWN on the respective grant; returns to IDLE on a no-grant cycle.
  - Used for rd_owner bookkeeping and debug display only.
- Simultaneous events:
  - A read accept and a rvalid for the previous read may occur in the same cycle.
  - A new request may be issued in the same cycle as its own rvalid.

Optional Feature:
- Macro: MEMORY_ARBITER_PERF_EN.
- Defined:
  - Adds outputs cpu_grant_count[31:0], dma_grant_count[31:0] and conflict_count[31:0] (cycles with both req high).
  - All are wrapping counters, cleared by RESET.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, CPU_OWN, DMA_OWN)
  - owner ids (OWNER_NONE=0, OWNER_CPU=1, OWNER_DMA=2)
  - function computing streak width from MAX_STREAK
- Sub-module arb_streak_counter: saturating counter with inc/clear inputs and an at_limit output. Instantiated once.

Test Plan:
- Reset mid-read: CPU read of 0x190 granted, RESET low on the next edge -> cpu_rvalid never asserts; all outputs 0 while reset is low.
- CPU only, read 0x190 with MEM[100]=0x04030201 -> cpu_grant same cycle; cpu_rvalid=1 next cycle with cpu_readData=0x04030201; dma_rvalid stays 0.
- DMA byte write: address 0x321, data 0x0000AB00, mask 4'b0010 with CPU idle -> mem_writeMask=4'b0010 and mem_address=0x321; a later CPU read of 0x320 returns byte1=0xAB.
- Continuous contention, both req held, MAX_STREAK=4 -> grant pattern C,C,C,C,D repeating; conflict_count increments every cycle when MEMORY_ARBITER_PERF_EN is defined.
- Alternating reads: CPU read 0x0 then DMA read 0x4 on consecutive cycles -> cpu_rvalid then dma_rvalid on consecutive cycles, each with its own word, no cross-routing.
- Read with nonzero mask: cpu_read=1, cpu_writeMask=4'b1111 -> mem_writeMask=0 and memory contents unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_e;

    // Bits needed to hold 0..max_streak; never narrower than one bit.
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 32'd2) ? 32'd1 : $clog2(max_streak + 32'd1);
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive contended CPU wins; clear has priority over increment.
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned CNT_W      = streak_width(MAX_STREAK)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_STREAK);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next-count selection with saturation at the limit.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// CPU/DMA arbiter for the single-port program/data memory with read-data return routing.
// Optional grant/conflict counters are enabled with MEMORY_ARBITER_PERF_EN.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic [31:0]       cpu_writeData,
    input  logic [3:0]        cpu_writeMask,
    output logic              cpu_grant,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_readData,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              dma_read,
    input  logic [31:0]       dma_writeData,
    input  logic [3:0]        dma_writeMask,
    output logic              dma_grant,
    output logic              dma_rvalid,
    output logic [31:0]       dma_readData,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic [31:0]       mem_writeData,
    output logic [3:0]        mem_writeMask,
`ifdef MEMORY_ARBITER_PERF_EN
    output logic [31:0]       cpu_grant_count,
    output logic [31:0]       dma_grant_count,
    output logic [31:0]       conflict_count,
`endif
    input  logic [31:0]       mem_readData
);

    arb_state_e  state_q;
    logic        rd_pending_q;
    owner_e      rd_owner_s;
    logic        at_limit_s;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dma_rdata_q;

    arb_streak_counter #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk        (CLK),
        .rst_n      (RESET),
        .inc_i      (cpu_grant & dma_req),
        .clr_i      (dma_grant | ~dma_req),
        .at_limit_o (at_limit_s)
    );

    // Fixed CPU priority, except DMA wins a contended cycle once the streak is exhausted.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (cpu_req && !(dma_req && at_limit_s)) begin
            cpu_grant = 1'b1;
        end else if (dma_req) begin
            dma_grant = 1'b1;
        end else begin
            cpu_grant = 1'b0;
            dma_grant = 1'b0;
        end
    end

    // Memory port mirrors the winner; a read never carries write lanes.
    always_comb begin
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_writeData = 32'h0000_0000;
        mem_writeMask = 4'b0000;
        if (cpu_grant) begin
            mem_address   = cpu_address;
            mem_read      = cpu_read;
            mem_writeData = cpu_writeData;
            mem_writeMask = cpu_read ? 4'b0000 : cpu_writeMask;
        end else if (dma_grant) begin
            mem_address   = dma_address;
            mem_read      = dma_read;
            mem_writeData = dma_writeData;
            mem_writeMask = dma_read ? 4'b0000 : dma_writeMask;
        end else begin
            mem_address   = '0;
            mem_read      = 1'b0;
        end
    end

    // Last-owner FSM; together with rd_pending_q it names who owns the returning read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= (cpu_grant & cpu_read) | (dma_grant & dma_read);
            case (state_q)
                IDLE, CPU_OWN, DMA_OWN: begin
                    if (cpu_grant) begin
                        state_q <= CPU_OWN;
                    end else if (dma_grant) begin
                        state_q <= DMA_OWN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_owner_s = !rd_pending_q         ? OWNER_NONE :
                        (state_q == CPU_OWN)  ? OWNER_CPU  :
                        (state_q == DMA_OWN)  ? OWNER_DMA  : OWNER_NONE;

    assign cpu_rvalid = (rd_owner_s == OWNER_CPU);
    assign dma_rvalid = (rd_owner_s == OWNER_DMA);

    // Memory data is only valid during the rvalid cycle, so capture it for the hold period.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cpu_rdata_q <= 32'h0000_0000;
            dma_rdata_q <= 32'h0000_0000;
        end else begin
            cpu_rdata_q <= cpu_rvalid ? mem_readData : cpu_rdata_q;
            dma_rdata_q <= dma_rvalid ? mem_readData : dma_rdata_q;
        end
    end

    assign cpu_readData = cpu_rvalid ? mem_readData : cpu_rdata_q;
    assign dma_readData = dma_rvalid ? mem_readData : dma_rdata_q;

`ifdef MEMORY_ARBITER_PERF_EN
    // Free-running wrapping performance counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cpu_grant_count <= 32'd0;
            dma_grant_count <= 32'd0;
            conflict_count  <= 32'd0;
        end else begin
            cpu_grant_count <= cpu_grant_count + {31'd0, cpu_grant};
            dma_grant_count <= dma_grant_count + {31'd0, dma_grant};
            conflict_count  <= conflict_count + {31'd0, cpu_req & dma_req};
        end
    end
`endif

endmodule
